ram_dp: RTL and testbench

Simple dual-port synchronous RAM: one write port and one read port on a single clock. It generalises the existing single-port `ram` block with:

- per-lane write masks;
- a selectable read-during-write result;
- an optional output pipeline register;
- a read-valid flag;
- a clear-on-reset sequencer that zero-fills the array before it accepts traffic.

It is used wherever a datapath needs a scratch buffer it can write and read in the same cycle.

---
 rtl/ram_dp.sv | 157 +++++++++++++++
 tb/tb_ram_dp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp.sv
// ram_dp: simple dual-port synchronous RAM (one write port, one read port, one clock).
// It provides per-lane write masks and a selectable read-during-write result.
// An optional output register and a read-valid flag are available.
// After reset, a sequencer zero-fills the array before the block reports ready.
//
// state  | meaning
// -------+-----------------------------------------------------------
// CLEAR  | zero-filling mem[clr_count], traffic ignored, ready = 0
// RUN    | normal operation, ready = 1
module ram_dp #(
    parameter int ADDRESS_BITS   = 6,
    parameter int DATA_BITS      = 8,
    parameter int LANE_BITS      = 8,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic                               ready,
    input  logic                               wr_en,
    input  logic [DATA_BITS/LANE_BITS-1:0]     wr_mask,
    input  logic [ADDRESS_BITS-1:0]            wr_address,
    input  logic [DATA_BITS-1:0]               wr_data,
    input  logic                               rd_en,
    input  logic [ADDRESS_BITS-1:0]            rd_address,
    output logic [DATA_BITS-1:0]               rd_data,
    output logic                               rd_valid
);

    localparam int DEPTH = 2 ** ADDRESS_BITS;
    localparam int LANES = DATA_BITS / LANE_BITS;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    localparam logic [ADDRESS_BITS-1:0] LAST_ADDRESS = ADDRESS_BITS'(DEPTH - 1);

    logic [0:0]              state;
    logic [ADDRESS_BITS-1:0] clr_count;
    logic                    ready_q;

    logic [DATA_BITS-1:0]    mem [DEPTH];

    logic                    wr_go;
    logic                    rd_go;
    logic [DATA_BITS-1:0]    old_word;
    logic [DATA_BITS-1:0]    merged_word;
    logic [DATA_BITS-1:0]    rd_word;

    logic [DATA_BITS-1:0]    s1_data;
    logic                    s1_valid;

    // A write landing on the reset edge is dropped so reset never alters contents.
    assign wr_go = ready_q & wr_en & ~rst;
    assign rd_go = ready_q & rd_en & ~rst;

    assign old_word = mem[rd_address];
    assign ready    = ready_q;

    // Word the read port would see if the same-cycle write were already applied.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (wr_mask[i]) begin
                merged_word[i*LANE_BITS +: LANE_BITS] = wr_data[i*LANE_BITS +: LANE_BITS];
            end
        end
    end

    // Select the read-during-write result for a same-address collision.
    always_comb begin
        rd_word = old_word;
        if (RDW_MODE != 0 && wr_go && (wr_address == rd_address)) begin
            rd_word = merged_word;
        end
    end

    // Sequencer: restart the zero-fill on reset, then stay in RUN until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_count <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_count <= clr_count + 1'b1;
                    if (clr_count == LAST_ADDRESS) begin
                        state   <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_RUN;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Array update: zero-fill while clearing, otherwise a lane-masked write.
    always_ff @(posedge clk) begin
        if (!rst && state == S_CLEAR) begin
            mem[clr_count] <= '0;
        end else if (wr_go) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_address][i*LANE_BITS +: LANE_BITS] <= wr_data[i*LANE_BITS +: LANE_BITS];
                end
            end
        end
    end

    // Read stage 1: capture the addressed word, hold it when no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_go;
            if (rd_go) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_BITS-1:0] s2_data;
            logic                 s2_valid;

            // Read stage 2: re-register stage 1 so the output comes straight from a flop.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_data  = s2_data;
            assign rd_valid = s2_valid;
        end else begin : g_no_out_reg
            assign rd_data  = s1_data;
            assign rd_valid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp.sv
// tb_ram_dp: two ram_dp instances share one stimulus stream.
// dut0 uses old-data read-during-write with latency 1; dut1 uses new data with latency 2.
// Expected reads are queued with their due cycle and checked when that cycle arrives.
module tb_ram_dp;

    localparam int AB = 6;
    localparam int DB = 32;
    localparam int LB = 8;
    localparam int LN = DB / LB;
    localparam int DEPTH = 2 ** AB;

    typedef struct {
        logic [DB-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [LN-1:0] wr_mask;
    logic [AB-1:0] wr_address;
    logic [DB-1:0] wr_data;
    logic          rd_en;
    logic [AB-1:0] rd_address;

    logic          ready0, ready1;
    logic [DB-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit bench_ready = 1'b0;

    logic [DB-1:0] model [DEPTH];
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    ram_dp #(.ADDRESS_BITS(AB), .DATA_BITS(DB), .LANE_BITS(LB),
             .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst(rst), .ready(ready0),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_address(wr_address), .wr_data(wr_data),
        .rd_en(rd_en), .rd_address(rd_address), .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    ram_dp #(.ADDRESS_BITS(AB), .DATA_BITS(DB), .LANE_BITS(LB),
             .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst(rst), .ready(ready1),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_address(wr_address), .wr_data(wr_data),
        .rd_en(rd_en), .rd_address(rd_address), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DB-1:0] merge(input logic [DB-1:0] old,
                                            input logic [DB-1:0] d,
                                            input logic [LN-1:0] m);
        logic [DB-1:0] r;
        r = old;
        for (int i = 0; i < LN; i++) begin
            if (m[i]) r[i*LB +: LB] = d[i*LB +: LB];
        end
        return r;
    endfunction

    // Drive one cycle of traffic; queue expected read results and update the model.
    task automatic step(input logic we, input logic [LN-1:0] mask, input logic [AB-1:0] wa,
                        input logic [DB-1:0] wd, input logic re, input logic [AB-1:0] ra);
        logic [DB-1:0] old_w, new_w;
        @(negedge clk);
        wr_en = we; wr_mask = mask; wr_address = wa; wr_data = wd;
        rd_en = re; rd_address = ra;
        if (bench_ready && !rst) begin
            if (re) begin
                old_w = model[ra];
                new_w = (we && wa == ra) ? merge(old_w, wd, mask) : old_w;
                q0.push_back('{old_w, cyc + 1});
                q1.push_back('{new_w, cyc + 2});
            end
            if (we) model[wa] = merge(model[wa], wd, mask);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Release reset while probing both ports, then count cycles until ready rises.
    task automatic wait_clear(input string tag);
        int n;
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b1; wr_mask = '1; wr_address = '0; wr_data = 32'hFFFF_FFFF;
        rd_en = 1'b1; rd_address = '0;
        n = 0;
        while (!ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        wr_en = 1'b0; rd_en = 1'b0; wr_mask = '0;
        check({tag, " clear cycles"}, DB'(n), DB'(DEPTH));
        check({tag, " ready1"}, DB'(ready1), 32'd1);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        bench_ready = 1'b1;
    endtask

    // dut0 monitor: a due entry needs rd_valid and data; otherwise rd_valid must be low.
    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            e0 = q0.pop_front();
            check("rd_valid0", DB'(rd_valid0), 32'd1);
            check("rd_data0", rd_data0, e0.data);
        end else if (rd_valid0) begin
            check("spurious rd_valid0", DB'(rd_valid0), 32'd0);
        end
    end

    // dut1 monitor, same rules with its own queue.
    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e1 = q1.pop_front();
            check("rd_valid1", DB'(rd_valid1), 32'd1);
            check("rd_data1", rd_data1, e1.data);
        end else if (rd_valid1) begin
            check("spurious rd_valid1", DB'(rd_valid1), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_mask = '0; wr_address = '0; wr_data = '0;
        rd_en = 1'b0; rd_address = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("reset ready0", DB'(ready0), 32'd0);
        check("reset ready1", DB'(ready1), 32'd0);
        check("reset rd_valid0", DB'(rd_valid0), 32'd0);
        check("reset rd_valid1", DB'(rd_valid1), 32'd0);
        check("reset rd_data0", rd_data0, 32'd0);
        check("reset rd_data1", rd_data1, 32'd0);

        // Clear sequence with traffic probes, then every word must read zero.
        wait_clear("initial");
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, '0, 1'b1, AB'(i));
        idle(3);

        // Masked writes.
        step(1'b1, 4'b1111, 6'd5, 32'hAABB_CCDD, 1'b0, '0);
        step(1'b1, 4'b0101, 6'd5, 32'h1122_3344, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 6'd5);
        idle(3);

        // A zero mask leaves the word unchanged.
        step(1'b1, 4'b0000, 6'd5, 32'hFFFF_FFFF, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 6'd5);
        idle(3);

        // Full-word collision, then a follow-up read.
        step(1'b1, 4'b1111, 6'd3, 32'h0000_0012, 1'b0, '0);
        step(1'b1, 4'b1111, 6'd3, 32'h0000_0034, 1'b1, 6'd3);
        step(1'b0, '0, '0, '0, 1'b1, 6'd3);
        idle(3);

        // Partial-mask collision returns the merged word in new-data mode.
        step(1'b1, 4'b1111, 6'd9, 32'hAABB_CCDD, 1'b0, '0);
        step(1'b1, 4'b0101, 6'd9, 32'h1122_3344, 1'b1, 6'd9);
        step(1'b0, '0, '0, '0, 1'b1, 6'd9);
        idle(3);

        // Independent addresses in the same cycle.
        step(1'b1, 4'b1111, 6'd11, 32'h5555_AAAA, 1'b0, '0);
        step(1'b1, 4'b1111, 6'd10, 32'hDEAD_BEEF, 1'b1, 6'd11);
        step(1'b0, '0, '0, '0, 1'b1, 6'd10);
        idle(3);

        // Streaming: fill with the index, then read back on consecutive cycles.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 4'b1111, AB'(i), DB'(i), 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, '0, 1'b1, AB'(i));
        idle(4);
        check("hold rd_data0", rd_data0, 32'd63);
        check("hold rd_data1", rd_data1, 32'd63);
        idle(2);
        check("hold2 rd_data0", rd_data0, 32'd63);
        check("hold2 rd_data1", rd_data1, 32'd63);

        // Reset with reads in flight: nothing that is still in a pipeline may emerge.
        step(1'b0, '0, '0, '0, 1'b1, 6'd7);
        @(negedge clk);
        rst = 1'b1; rd_en = 1'b1; rd_address = 6'd8;
        bench_ready = 1'b0;
        while (q0.size() > 0 && q0[q0.size()-1].cyc >= cyc + 1) void'(q0.pop_back());
        while (q1.size() > 0 && q1[q1.size()-1].cyc >= cyc + 1) void'(q1.pop_back());
        @(negedge clk);
        check("mid reset rd_data0", rd_data0, 32'd0);
        check("mid reset rd_data1", rd_data1, 32'd0);
        check("mid reset ready0", DB'(ready0), 32'd0);
        wait_clear("after run reset");
        step(1'b0, '0, '0, '0, 1'b1, 6'd5);
        step(1'b0, '0, '0, '0, 1'b1, 6'd63);
        idle(3);

        // Reset at clear count 30 restarts the full zero-fill.
        @(negedge clk);
        rst = 1'b1;
        bench_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("mid clear ready0", DB'(ready0), 32'd0);
        rst = 1'b1;
        wait_clear("after clear reset");
        step(1'b0, '0, '0, '0, 1'b1, 6'd40);
        idle(3);

        check("q0 drained", DB'(q0.size()), 32'd0);
        check("q1 drained", DB'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
